// File: rtl/cpu16_bus_arbiter.sv
// Shares the CPU16 RAM port between the core and one DMA master, stalling the core only at
// instruction boundaries via hold/busy, with bounded DMA bursts and a guaranteed CPU window.
module cpu16_bus_arbiter #(
    parameter int MAX_BURST      = 8,
    parameter int MIN_CPU_CYCLES = 4,
    parameter int RAM_WAIT       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [15:0] cpu_data_out,
    input  logic        cpu_write,
    input  logic        cpu_busy,
    output logic        cpu_hold,
    output logic [15:0] cpu_data_in,
    input  logic        dma_req,
    output logic        dma_gnt,
    input  logic [15:0] dma_address,
    input  logic [15:0] dma_wdata,
    input  logic        dma_we,
    output logic [15:0] dma_rdata,
    output logic        dma_rvalid,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic        mem_write,
    input  logic [15:0] mem_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(MIN_CPU_CYCLES + 1);

    typedef enum logic [2:0] {
        S_CPU,
        S_HOLD,
        S_DMA,
        S_DRAIN,
        S_COOL
    } state_t;

    state_t        state_reg;
    logic [BW-1:0] burst_cnt_reg;
    logic [CW-1:0] cool_cnt_reg;
    logic          cpu_hold_reg;
    logic          rvalid_reg;

    logic dma_accept;
    logic dma_read_accept;
    logic burst_last;
    logic cool_last;

    assign dma_accept      = (state_reg == S_DMA) && dma_req;
    assign dma_read_accept = dma_accept && !dma_we;
    assign burst_last      = (burst_cnt_reg == BW'(MAX_BURST - 1));
    assign cool_last       = (cool_cnt_reg == CW'(MIN_CPU_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_CPU;
            cpu_hold_reg  <= 1'b0;
            burst_cnt_reg <= '0;
            cool_cnt_reg  <= '0;
            rvalid_reg    <= 1'b0;
        end else begin
            rvalid_reg <= dma_read_accept;
            case (state_reg)
                S_CPU: begin
                    if (dma_req) begin
                        state_reg    <= S_HOLD;
                        cpu_hold_reg <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A busy core with no store pending is parked at an instruction boundary.
                    if (!dma_req) begin
                        state_reg    <= S_CPU;
                        cpu_hold_reg <= 1'b0;
                    end else if (cpu_busy && !cpu_write) begin
                        state_reg     <= S_DMA;
                        burst_cnt_reg <= '0;
                    end
                end
                S_DMA: begin
                    if (!dma_req || burst_last) begin
                        if (RAM_WAIT == 0) begin
                            state_reg    <= S_COOL;
                            cpu_hold_reg <= 1'b0;
                            cool_cnt_reg <= '0;
                        end else begin
                            state_reg <= S_DRAIN;
                        end
                    end else begin
                        burst_cnt_reg <= burst_cnt_reg + BW'(1);
                    end
                end
                S_DRAIN: begin
                    state_reg    <= S_COOL;
                    cpu_hold_reg <= 1'b0;
                    cool_cnt_reg <= '0;
                end
                S_COOL: begin
                    if (cool_last) begin
                        state_reg <= S_CPU;
                    end else begin
                        cool_cnt_reg <= cool_cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg    <= S_CPU;
                    cpu_hold_reg <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_address = cpu_address;
        mem_wdata   = cpu_data_out;
        mem_write   = cpu_write;
        case (state_reg)
            S_DMA: begin
                mem_address = dma_address;
                mem_wdata   = dma_wdata;
                mem_write   = dma_we && dma_req;
            end
            S_DRAIN: begin
                mem_address = dma_address;
                mem_wdata   = dma_wdata;
                mem_write   = 1'b0;
            end
            default: begin
                mem_address = cpu_address;
                mem_wdata   = cpu_data_out;
                mem_write   = cpu_write;
            end
        endcase
    end

    // With a zero-latency RAM the read data is already on mem_rdata in the accepting cycle.
    generate
        if (RAM_WAIT == 0) begin : g_rvalid_comb
            assign dma_rvalid = dma_read_accept;
        end else begin : g_rvalid_reg
            assign dma_rvalid = rvalid_reg;
        end
    endgenerate

    assign cpu_hold    = cpu_hold_reg;
    assign dma_gnt     = (state_reg == S_DMA);
    assign cpu_data_in = mem_rdata;
    assign dma_rdata   = mem_rdata;

endmodule

// File: tb/tb_cpu16_bus_arbiter.sv
// Directed bench for cpu16_bus_arbiter: bench-side RAM with one-cycle registered read,
// core and DMA behaviour driven step by step from a single initial block.
module tb_cpu16_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_address;
    logic [15:0] cpu_data_out;
    logic        cpu_write;
    logic        cpu_busy;
    logic        cpu_hold;
    logic [15:0] cpu_data_in;
    logic        dma_req;
    logic        dma_gnt;
    logic [15:0] dma_address;
    logic [15:0] dma_wdata;
    logic        dma_we;
    logic [15:0] dma_rdata;
    logic        dma_rvalid;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic [15:0] mem_rdata;

    logic [15:0] ram [0:65535];

    int tests = 0;
    int fails = 0;

    cpu16_bus_arbiter #(
        .MAX_BURST      (8),
        .MIN_CPU_CYCLES (4),
        .RAM_WAIT       (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_address  (cpu_address),
        .cpu_data_out (cpu_data_out),
        .cpu_write    (cpu_write),
        .cpu_busy     (cpu_busy),
        .cpu_hold     (cpu_hold),
        .cpu_data_in  (cpu_data_in),
        .dma_req      (dma_req),
        .dma_gnt      (dma_gnt),
        .dma_address  (dma_address),
        .dma_wdata    (dma_wdata),
        .dma_we       (dma_we),
        .dma_rdata    (dma_rdata),
        .dma_rvalid   (dma_rvalid),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) ram[mem_address] <= mem_wdata;
        mem_rdata <= ram[mem_address];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          n;
    int          g1;
    int          g2;
    int          gap;
    int          drain;
    int          fetches;
    logic        first_done;
    logic        accepted;
    logic [15:0] a;

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
        reset        = 1'b1;
        cpu_address  = 16'hF000;
        cpu_data_out = 16'h0000;
        cpu_write    = 1'b0;
        cpu_busy     = 1'b0;
        dma_req      = 1'b0;
        dma_address  = 16'h0000;
        dma_wdata    = 16'h0000;
        dma_we       = 1'b0;
        step();
        step();
        check("reset_hold", {15'd0, cpu_hold}, 16'd0);
        check("reset_gnt", {15'd0, dma_gnt}, 16'd0);
        check("reset_rvalid", {15'd0, dma_rvalid}, 16'd0);
        reset = 1'b0;

        // 1: core runs from 0xF000, the RAM address follows it every cycle
        for (int i = 0; i < 4; i++) begin
            cpu_address = 16'hF000 + 16'(i);
            #1;
            check("t1_mem_addr", mem_address, 16'hF000 + 16'(i));
            check("t1_gnt", {15'd0, dma_gnt}, 16'd0);
            step();
            check("t1_hold", {15'd0, cpu_hold}, 16'd0);
        end

        // 2: DMA write requested while the core is mid-instruction with a store still to come
        cpu_address = 16'hF004;
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_address = 16'h7000;
        dma_wdata   = 16'h1234;
        #1;
        check("t2_cpu_owns", mem_address, 16'hF004);
        step();
        check("t2_hold_next", {15'd0, cpu_hold}, 16'd1);
        check("t2_no_gnt_busy0", {15'd0, dma_gnt}, 16'd0);
        cpu_busy     = 1'b1;
        cpu_write    = 1'b1;
        cpu_address  = 16'h2000;
        cpu_data_out = 16'h5555;
        #1;
        check("t2_cpu_store_addr", mem_address, 16'h2000);
        check("t2_cpu_store_we", {15'd0, mem_write}, 16'd1);
        step();
        check("t2_no_gnt_store", {15'd0, dma_gnt}, 16'd0);
        cpu_write   = 1'b0;
        cpu_address = 16'hF005;
        step();
        check("t2_gnt", {15'd0, dma_gnt}, 16'd1);
        check("t2_dma_addr", mem_address, 16'h7000);
        check("t2_dma_wdata", mem_wdata, 16'h1234);
        check("t2_dma_we", {15'd0, mem_write}, 16'd1);
        step();
        dma_req = 1'b0;
        #1;
        check("t2_we_gated", {15'd0, mem_write}, 16'd0);
        step();
        check("t2_drain_hold", {15'd0, cpu_hold}, 16'd1);
        check("t2_drain_gnt", {15'd0, dma_gnt}, 16'd0);
        step();
        check("t2_cool_hold", {15'd0, cpu_hold}, 16'd0);
        check("t2_fetch_addr", mem_address, 16'hF005);
        check("t2_ram_dma", ram[16'h7000], 16'h1234);
        check("t2_ram_cpu", ram[16'h2000], 16'h5555);
        cpu_busy = 1'b0;
        repeat (6) step();

        // 3: single DMA read of a preloaded word, core already parked
        ram[16'h0042] = 16'hBEEF;
        dma_req     = 1'b1;
        dma_we      = 1'b0;
        dma_address = 16'h0042;
        cpu_busy    = 1'b1;
        step();
        step();
        check("t3_gnt", {15'd0, dma_gnt}, 16'd1);
        check("t3_rvalid_early", {15'd0, dma_rvalid}, 16'd0);
        step();
        dma_req = 1'b0;
        #1;
        check("t3_rvalid", {15'd0, dma_rvalid}, 16'd1);
        check("t3_rdata", dma_rdata, 16'hBEEF);
        check("t3_cpu_data_in", cpu_data_in, 16'hBEEF);
        step();
        check("t3_rvalid_pulse", {15'd0, dma_rvalid}, 16'd0);
        cpu_busy = 1'b0;
        repeat (6) step();

        // 4: ten writes with dma_req held; the burst is split at eight
        n = 0; g1 = 0; g2 = 0; gap = 0; drain = 0; fetches = 0; first_done = 1'b0;
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_address = 16'h7100;
        dma_wdata   = 16'hA000;
        for (int c = 0; c < 30; c++) begin
            if (dma_gnt && dma_req) begin
                if (!first_done) g1++;
                else g2++;
            end
            if (!first_done && g1 > 0 && !dma_gnt) first_done = 1'b1;
            if (first_done && g2 == 0 && cpu_hold && !dma_gnt && gap == 0) drain++;
            if (first_done && g2 == 0 && !cpu_hold) gap++;
            accepted = dma_gnt && dma_req;
            step();
            if (accepted) begin
                n++;
                dma_address = 16'h7100 + 16'(n);
                dma_wdata   = 16'hA000 + 16'(n);
                if (n == 10) dma_req = 1'b0;
            end
            cpu_busy = cpu_hold;
            if (!cpu_hold) begin
                cpu_address = cpu_address + 16'd1;
                if (first_done && g2 == 0) fetches++;
            end
        end
        check("t4_burst1", 16'(g1), 16'd8);
        check("t4_drain", 16'(drain), 16'd1);
        check("t4_gap_min", {15'd0, gap >= 4}, 16'd1);
        check("t4_fetch", {15'd0, fetches >= 1}, 16'd1);
        check("t4_burst2", 16'(g2), 16'd2);
        check("t4_end_hold", {15'd0, cpu_hold}, 16'd0);
        for (int k = 0; k < 10; k++) begin
            a = 16'h7100 + 16'(k);
            check("t4_ram", ram[a], 16'hA000 + 16'(k));
        end

        // 5: request withdrawn while waiting for the core to park
        cpu_busy    = 1'b0;
        cpu_write   = 1'b0;
        dma_req     = 1'b1;
        dma_we      = 1'b1;
        dma_address = 16'h7200;
        dma_wdata   = 16'hDEAD;
        step();
        check("t5_hold", {15'd0, cpu_hold}, 16'd1);
        dma_req = 1'b0;
        #1;
        check("t5_no_write", {15'd0, mem_write}, 16'd0);
        step();
        check("t5_hold_drop", {15'd0, cpu_hold}, 16'd0);
        check("t5_no_gnt", {15'd0, dma_gnt}, 16'd0);
        cpu_busy = 1'b1;
        step();
        check("t5_still_no_gnt", {15'd0, dma_gnt}, 16'd0);
        check("t5_ram", ram[16'h7200], 16'h0000);
        cpu_busy = 1'b0;
        step();

        // 6: reset lands on the third read of a burst
        dma_req     = 1'b1;
        dma_we      = 1'b0;
        dma_address = 16'h0042;
        cpu_busy    = 1'b1;
        step();
        step();
        check("t6_gnt", {15'd0, dma_gnt}, 16'd1);
        step();
        check("t6_rvalid_t1", {15'd0, dma_rvalid}, 16'd1);
        step();
        reset = 1'b1;
        step();
        check("t6_rst_hold", {15'd0, cpu_hold}, 16'd0);
        check("t6_rst_gnt", {15'd0, dma_gnt}, 16'd0);
        check("t6_rst_rvalid", {15'd0, dma_rvalid}, 16'd0);
        reset = 1'b0;
        step();
        check("t6_rehold", {15'd0, cpu_hold}, 16'd1);
        check("t6_regnt_wait", {15'd0, dma_gnt}, 16'd0);
        step();
        check("t6_regnt", {15'd0, dma_gnt}, 16'd1);
        dma_req = 1'b0;
        repeat (7) step();
        check("t6_final_hold", {15'd0, cpu_hold}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
